// File: rtl/operand_stream_adder_pkg.sv
// Shared types and width helpers for the operand stream adder.
package operand_stream_adder_pkg;

  // ACCUM: output slot free, groups may close.
  // STALL: output slot holds an unconsumed result; a closing operand must wait.
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    STALL = 1'b1
  } osa_state_e;

  // Sum width wide enough for group * (2^width - 1) without wrap.
  function automatic int osa_sum_w(input int width, input int group);
    return width + $clog2(group);
  endfunction

  // Counter width able to hold the value group itself.
  function automatic int osa_cnt_w(input int group);
    return $clog2(group + 1);
  endfunction

endpackage

// File: rtl/operand_stream_adder_if.sv
// Operand input stream and result output stream of the operand stream adder.
interface operand_stream_adder_if
  import operand_stream_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GROUP = 9
);
  localparam int SUM_W = osa_sum_w(WIDTH, GROUP);
  localparam int CNT_W = osa_cnt_w(GROUP);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  // The adder itself.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/operand_stream_adder_out_slot.sv
// Single-entry output register with valid/ready handshake for completed groups.
module osa_out_slot #(
  parameter int SUM_W = 12,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [SUM_W-1:0] load_sum_i,
  input  logic [CNT_W-1:0] load_count_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [SUM_W-1:0] out_sum_o,
  output logic [CNT_W-1:0] out_count_o
);

  logic             valid_q, valid_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Load wins over drain so a close coinciding with a consume leaves no bubble;
  // data holds its last value after a drain.
  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    count_d = count_q;
    if (load_i) begin
      valid_d = 1'b1;
      sum_d   = load_sum_i;
      count_d = load_count_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_sum_o   = sum_q;
  assign out_count_o = count_q;

endmodule

// File: rtl/operand_stream_adder.sv
// Accumulates unsigned operands into groups of GROUP (or fewer when in_last)
// and presents each group's sum and operand count on a valid/ready output.
module operand_stream_adder
  import operand_stream_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GROUP = 9
) (
  input logic                  clk,
  input logic                  rst_n,
  operand_stream_adder_if.slave bus
);

  localparam int SUM_W = osa_sum_w(WIDTH, GROUP);
  localparam int CNT_W = osa_cnt_w(GROUP);
  localparam logic [CNT_W-1:0] GROUP_C = CNT_W'(GROUP);

  osa_state_e       state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SUM_W-1:0] sum_next_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             closing_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             close_s;

  logic             slot_valid_s;
  logic [SUM_W-1:0] slot_sum_s;
  logic [CNT_W-1:0] slot_count_s;

  // Handshake decode; in_ready depends only on cnt, in_last, out_ready and
  // state so there is no path from in_valid to in_ready.
  always_comb begin
    cnt_next_s = cnt_q + CNT_W'(1);
    sum_next_s = acc_q + SUM_W'(bus.in_data);
    closing_s  = (cnt_next_s == GROUP_C) || bus.in_last;
    in_ready_s = !((state_q == STALL) && !bus.out_ready) || !closing_s;
    accept_s   = bus.in_valid && in_ready_s;
    close_s    = accept_s && closing_s;
  end

  // Accumulator and counter update; a closing operand clears both so the
  // next group starts from zero in the same cycle the result is loaded.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (close_s) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept_s) begin
      acc_d = sum_next_s;
      cnt_d = cnt_next_s;
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // Next state: STALL whenever the output slot will hold a result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: begin
        if (close_s) state_d = STALL;
        else         state_d = ACCUM;
      end
      STALL: begin
        if (close_s)            state_d = STALL;
        else if (bus.out_ready) state_d = ACCUM;
        else                    state_d = STALL;
      end
      default: state_d = ACCUM;
    endcase
  end

  // State, accumulator and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  osa_out_slot #(
    .SUM_W (SUM_W),
    .CNT_W (CNT_W)
  ) u_out_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (close_s),
    .load_sum_i   (sum_next_s),
    .load_count_i (cnt_next_s),
    .out_ready_i  (bus.out_ready),
    .out_valid_o  (slot_valid_s),
    .out_sum_o    (slot_sum_s),
    .out_count_o  (slot_count_s)
  );

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = slot_valid_s;
  assign bus.out_sum   = slot_sum_s;
  assign bus.out_count = slot_count_s;

endmodule

// File: tb/tb_operand_stream_adder.sv
// Directed scoreboard bench for operand_stream_adder (WIDTH=8, GROUP=9).
module tb_operand_stream_adder;

  localparam int WIDTH = 8;
  localparam int GROUP = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  operand_stream_adder_if #(.WIDTH(WIDTH), .GROUP(GROUP)) bus ();

  operand_stream_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [11:0] sum;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   n_results = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input int sum, input int cnt);
    exp_t e;
    e.sum = 12'(sum);
    e.cnt = 4'(cnt);
    exp_q.push_back(e);
  endtask

  // Present one operand and hold it until accepted (bounded).
  task automatic send(input logic [7:0] d, input logic l, output logic first_rdy);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
    first_rdy = bus.in_ready;
    for (int k = 0; k < 50 && !done; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("send_accept", int'(done), 1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'd0;
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks that a
  // stalled result stays stable.
  bit          hold_v = 1'b0;
  logic [11:0] hold_sum = 12'd0;
  logic [3:0]  hold_cnt = 4'd0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stable_sum", int'(bus.out_sum), int'(hold_sum));
        chk("stable_count", int'(bus.out_count), int'(hold_cnt));
      end
      if (bus.out_valid && bus.out_ready) begin
        n_results++;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("out_sum", int'(bus.out_sum), int'(e.sum));
          chk("out_count", int'(bus.out_count), int'(e.cnt));
        end
        hold_v = 1'b0;
      end else if (bus.out_valid) begin
        hold_v   = 1'b1;
        hold_sum = bus.out_sum;
        hold_cnt = bus.out_count;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    logic r;
    bus.out_ready = 1'b1;
    // Operands presented during reset must be dropped.
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd100;
    bus.in_last  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_sum", int'(bus.out_sum), 0);
    chk("rst_count", int'(bus.out_count), 0);
    idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", int'(bus.out_valid), 0);

    // 1..9 back-to-back: 45/9, visible one cycle after the 9th accept.
    for (int i = 1; i <= 9; i++) begin
      if (i == 9) push(45, 9);
      send(8'(i), 1'b0, r);
    end
    idle();
    chk("lat_valid", int'(bus.out_valid), 1);
    chk("lat_sum", int'(bus.out_sum), 45);
    @(posedge clk);
    #1;
    chk("drain_valid", int'(bus.out_valid), 0);
    chk("drain_hold_sum", int'(bus.out_sum), 45);

    // Nine operands of 255: 2295 with no wrap.
    for (int i = 1; i <= 9; i++) begin
      if (i == 9) push(2295, 9);
      send(8'd255, 1'b0, r);
    end

    // Early close with in_last, then single-operand group from zero.
    send(8'd10, 1'b0, r);
    send(8'd20, 1'b0, r);
    push(60, 3);
    send(8'd30, 1'b1, r);
    push(4, 1);
    send(8'd4, 1'b1, r);

    // Close while previous result is being consumed: no bubble.
    push(5, 1);
    send(8'd5, 1'b1, r);
    push(6, 1);
    send(8'd6, 1'b1, r);
    idle();
    chk("nobubble_valid", int'(bus.out_valid), 1);
    chk("nobubble_sum", int'(bus.out_sum), 6);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: 18 ones, only the 18th (closing) operand stalls.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      if (i == 9) push(9, 9);
      send(8'd1, 1'b0, r);
      chk("bp_ready", int'(r), 1);
    end
    push(9, 9);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd1;
    bus.in_last  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall_ready", int'(bus.in_ready), 0);
      chk("bp_stall_sum", int'(bus.out_sum), 9);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    idle();
    chk("bp_nobubble_valid", int'(bus.out_valid), 1);
    repeat (2) @(posedge clk);
    #1;

    // Reset with a pending result and a partial group of 7s.
    bus.out_ready = 1'b0;
    send(8'd3, 1'b1, r);
    for (int i = 0; i < 5; i++) send(8'd7, 1'b0, r);
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_sum", int'(bus.out_sum), 0);
    chk("mid_rst_count", int'(bus.out_count), 0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (i == 9) push(18, 9);
      send(8'd2, 1'b0, r);
    end
    idle();
    repeat (4) @(posedge clk);
    #1;

    chk("queue_empty", exp_q.size(), 0);
    chk("result_count", n_results, 9);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/operand_stream_adder.md
OPERAND_STREAM_ADDER -- requirements
Module: operand_stream_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits.
REQ-002 Parameter GROUP, default 9, operands per full group (legal range 2..255).
REQ-003 Derived constant SUM_W = WIDTH + $clog2(GROUP); CNT_W = $clog2(GROUP+1).
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  operand present on in_data.
REQ-007 in_ready  output  1  block accepts operand this cycle.
REQ-008 in_data  input  WIDTH  unsigned operand.
REQ-009 in_last  input  1  operand closes current group early; qualified by in_valid.
REQ-010 out_valid  output  1  out_sum/out_count hold a completed group.
REQ-011 out_ready  input  1  downstream consumes result this cycle.
REQ-012 out_sum  output  SUM_W  unsigned sum of group operands.
REQ-013 out_count  output  CNT_W  number of operands in the reported group (1..GROUP).

Function
REQ-014 Operand accepted on cycle where in_valid && in_ready; result accepted where out_valid && out_ready.
REQ-015 Accumulator acc (SUM_W) and counter cnt (CNT_W); on accepted operand: acc <= acc + in_data (zero-extended), cnt <= cnt + 1.
REQ-016 Group closes on accepted operand when cnt+1 == GROUP or in_last == 1.
REQ-017 On close: out_sum <= acc + in_data, out_count <= cnt + 1, out_valid <= 1, acc <= 0, cnt <= 0, all in same cycle; latency last operand -> out_valid = 1 cycle.
REQ-018 Sum never overflows: SUM_W covers GROUP * (2^WIDTH - 1); no truncation, no wrap.
REQ-019 FSM states: ACCUM (accepting, output slot free or being drained), STALL (group complete, output slot full, next group must not close).
REQ-020 in_ready = 1 unless cnt+1 would close a group while out_valid && !out_ready; operands that do not close a group are accepted regardless of output backpressure.
REQ-021 Simplification permitted: in_ready = !(out_valid && !out_ready) || (cnt+1 < GROUP && !in_last); combinational from out_ready, in_last, cnt only (no in_valid dependency).
REQ-022 Simultaneous close and output consume (out_valid && out_ready && closing operand): new result loaded, out_valid stays 1, no bubble.
REQ-023 Output consume with no close: out_valid <= 0 next cycle; out_sum/out_count hold last value.
REQ-024 out_sum/out_count stable while out_valid && !out_ready.
REQ-025 in_last on first operand of a group yields out_count = 1, out_sum = operand.
REQ-026 in_data, in_last ignored when in_valid = 0.

Reset
REQ-027 While rst_n = 0 at posedge clk: acc = 0, cnt = 0, out_valid = 0, out_sum = 0, out_count = 0, state = ACCUM.
REQ-028 Reset mid-group discards partial sum; reset while out_valid discards pending result; no output after reset until a new group closes.
REQ-029 in_ready may be 1 during reset; operands presented during reset are dropped.

Structure
REQ-030 Shared package holds state enum (ACCUM, STALL) and SUM_W/CNT_W derivation functions.
REQ-031 Single module; one optional sub-module, osa_out_slot, holding the output register and valid/ready logic.
REQ-032 No combinational path from in_valid to in_ready or from in_data to any output.

Verification
REQ-033 WIDTH=8, GROUP=9, operands 1..9 back-to-back, out_ready=1 -> one result out_sum=45, out_count=9, one cycle after 9th accept.
REQ-034 Nine operands of 255 -> out_sum=2295 (no overflow), out_count=9.
REQ-035 Operands 10,20,30 with in_last on 30 -> out_sum=60, out_count=3; next group starts at acc=0.
REQ-036 out_ready=0 held, two full groups of 1s streamed -> first result 9 held stable, in_ready=0 only on 18th operand; release out_ready -> 9, then 9, no loss.
REQ-037 Closing operand accepted in same cycle as out_ready consume -> out_valid stays 1, new sum appears next cycle, no bubble.
REQ-038 rst_n=0 after 5 operands of 7 -> outputs zero; next 9 operands of 2 -> out_sum=18, out_count=9.
